player_motion: RTL and testbench



---
 rtl/motion_pkg.sv | 27 ++
 rtl/frame_tick.sv | 48 ++++
 rtl/player_motion.sv | 119 +++++++++++
 tb/tb_player_motion.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared motion types and default physics constants for the player motion engine.
package motion_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_e;

  localparam int DEF_START_X  = 100;
  localparam int DEF_START_Y  = 400;
  localparam int DEF_X_STEP   = 2;
  localparam int DEF_JUMP_V   = 8;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_MAX_FALL = 8;

  function automatic logic signed [31:0] clamp_pos(input logic signed [31:0] v,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    logic signed [31:0] r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Brings an asynchronous frame-rate clock into the Clk domain as a registered
// one-cycle tick on each rising edge, three Clk cycles after that edge.
module frame_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_in,
  output logic tick
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [1:0] valid_q, valid_d;
  logic       armed_q, armed_d;
  logic       tick_q, tick_d;

  // Edges are only accepted once the synchronized input has been seen low,
  // so a frame clock already high at reset release does not produce a tick.
  always_comb begin
    sync1_d = frame_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    valid_d = {valid_q[0], 1'b1};
    armed_d = armed_q | (valid_q[1] & ~sync2_q);
    tick_d  = sync2_q & ~prev_q & armed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      valid_q <= 2'b00;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/player_motion.sv
// Per-player motion engine: once per frame tick, steps X from the arrow keys and
// Y from jump/gravity physics, resolved against the collision window.
module player_motion
  import motion_pkg::*;
#(
  parameter int START_X  = DEF_START_X,
  parameter int START_Y  = DEF_START_Y,
  parameter int X_STEP   = DEF_X_STEP,
  parameter int JUMP_V   = DEF_JUMP_V,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               freeze,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_jump,
  input  logic signed [31:0] player_X_Min,
  input  logic signed [31:0] player_X_Max,
  input  logic signed [31:0] player_Y_Min,
  input  logic signed [31:0] player_Y_Max,
  output logic signed [31:0] player_X_Pos,
  output logic signed [31:0] player_Y_Pos,
  output logic signed [31:0] player_Y_Vel,
  output logic               grounded
);

  localparam int FALL_START = (GRAVITY < MAX_FALL) ? GRAVITY : MAX_FALL;

  logic               tick;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] vy_q, vy_d;
  motion_state_e      state_q, state_d;

  logic signed [31:0] vx;
  logic signed [31:0] vy_step;
  logic signed [31:0] vy_grav;
  logic signed [31:0] y_sum;
  motion_state_e      state_step;

  frame_tick u_frame_tick (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .frame_in(frame_clk),
    .tick    (tick)
  );

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    vy_d       = vy_q;
    state_d    = state_q;
    vx         = '0;
    vy_step    = vy_q;
    state_step = state_q;

    if (key_right && !key_left)      vx = X_STEP;
    else if (key_left && !key_right) vx = -X_STEP;

    vy_grav = vy_q + GRAVITY;
    if (vy_grav > MAX_FALL) vy_grav = MAX_FALL;

    case (state_q)
      GROUND: begin
        if (key_jump) begin
          vy_step    = -JUMP_V;
          state_step = RISE;
        end else if (y_q < player_Y_Max) begin
          vy_step    = FALL_START;
          state_step = FALL;
        end
      end
      default: vy_step = vy_grav;
    endcase

    y_sum = y_q + vy_step;

    // Landing takes priority over a head bump when the window is degenerate.
    if (tick && !freeze) begin
      x_d = clamp_pos(x_q + vx, player_X_Min, player_X_Max);
      if (y_sum >= player_Y_Max) begin
        y_d     = player_Y_Max;
        vy_d    = '0;
        state_d = GROUND;
      end else if (y_sum < player_Y_Min) begin
        y_d     = player_Y_Min;
        vy_d    = '0;
        state_d = FALL;
      end else begin
        y_d     = y_sum;
        vy_d    = vy_step;
        state_d = (state_step == RISE && vy_step >= 0) ? FALL : state_step;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q     <= START_X;
      y_q     <= START_Y;
      vy_q    <= '0;
      state_q <= FALL;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      state_q <= state_d;
    end
  end

  assign player_X_Pos = x_q;
  assign player_Y_Pos = y_q;
  assign player_Y_Vel = vy_q;
  assign grounded     = (state_q == GROUND);

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: scripted frame table, corner-case
// sequences and randomized frames against a rule-level motion model.
module tb_player_motion;

  localparam int START_X = 100;
  localparam int START_Y = 400;
  localparam int STEP_X  = 2;
  localparam int JUMP    = 8;
  localparam int GRAV    = 1;
  localparam int VMAX    = 8;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               frame_clk;
  logic               freeze;
  logic               key_left, key_right, key_jump;
  logic signed [31:0] player_X_Min, player_X_Max, player_Y_Min, player_Y_Max;
  logic signed [31:0] player_X_Pos, player_Y_Pos, player_Y_Vel;
  logic               grounded;

  int nCompared   = 0;
  int nMismatched = 0;

  // Rule-level model: position, velocity and whether the player stands on ground.
  int mX, mY, mVy;
  bit mOnGround;

  typedef struct {
    bit l, r, j;
    int yMin, yMax;
    int expX, expY, expVy;
    bit expG;
  } vec_t;

  vec_t tbl[$];

  player_motion dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .freeze      (freeze),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_jump    (key_jump),
    .player_X_Min(player_X_Min),
    .player_X_Max(player_X_Max),
    .player_Y_Min(player_Y_Min),
    .player_Y_Max(player_Y_Max),
    .player_X_Pos(player_X_Pos),
    .player_Y_Pos(player_Y_Pos),
    .player_Y_Vel(player_Y_Vel),
    .grounded    (grounded)
  );

  always #5 Clk = ~Clk;

  task automatic modelReset();
    mX = START_X;
    mY = START_Y;
    mVy = 0;
    mOnGround = 1'b0;
  endtask

  task automatic modelStep(input bit l, input bit r, input bit j,
                           input int xmin, input int xmax, input int ymin, input int ymax);
    int nx, v, ny;
    nx = mX + ((r && !l) ? STEP_X : (l && !r) ? -STEP_X : 0);
    if (nx < xmin) nx = xmin;
    if (nx > xmax) nx = xmax;
    if (mOnGround && j)            v = -JUMP;
    else if (mOnGround && mY < ymax) v = (GRAV < VMAX) ? GRAV : VMAX;
    else if (mOnGround)            v = mVy;
    else                           v = (mVy + GRAV < VMAX) ? mVy + GRAV : VMAX;
    ny = mY + v;
    mX = nx;
    if (ny >= ymax) begin
      mY = ymax; mVy = 0; mOnGround = 1'b1;
    end else if (ny < ymin) begin
      mY = ymin; mVy = 0; mOnGround = 1'b0;
    end else begin
      mY = ny; mVy = v; mOnGround = 1'b0;
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".x"},  player_X_Pos, mX);
    checkValue({tag, ".y"},  player_Y_Pos, mY);
    checkValue({tag, ".vy"}, player_Y_Vel, mVy);
    checkValue({tag, ".grounded"}, int'(grounded), int'(mOnGround));
  endtask

  task automatic pulseFrame();
    frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic applyStimulus(input bit l, input bit r, input bit j, input bit frz,
                               input int xmin, input int xmax, input int ymin, input int ymax);
    @(negedge Clk);
    key_left = l; key_right = r; key_jump = j; freeze = frz;
    player_X_Min = xmin; player_X_Max = xmax;
    player_Y_Min = ymin; player_Y_Max = ymax;
    pulseFrame();
    if (!frz) modelStep(l, r, j, xmin, xmax, ymin, ymax);
  endtask

  function automatic vec_t mk(bit l, bit r, bit j, int ex, int ey, int evy, bit eg);
    vec_t v;
    v.l = l; v.r = r; v.j = j; v.yMin = 0; v.yMax = 415;
    v.expX = ex; v.expY = ey; v.expVy = evy; v.expG = eg;
    return v;
  endfunction

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; freeze = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
    player_X_Min = 0; player_X_Max = 639; player_Y_Min = 0; player_Y_Max = 415;

    // fall from reset, jump to the apex while steering, then fall back down
    tbl.push_back(mk(0,0,0, 100,401,1,0));
    tbl.push_back(mk(0,0,0, 100,403,2,0));
    tbl.push_back(mk(0,0,0, 100,406,3,0));
    tbl.push_back(mk(0,0,0, 100,410,4,0));
    tbl.push_back(mk(0,0,0, 100,415,0,1));
    tbl.push_back(mk(0,0,1, 100,407,-8,0));
    tbl.push_back(mk(0,1,0, 102,400,-7,0));
    tbl.push_back(mk(0,1,0, 104,394,-6,0));
    tbl.push_back(mk(0,1,0, 106,389,-5,0));
    tbl.push_back(mk(0,1,0, 108,385,-4,0));
    tbl.push_back(mk(1,0,0, 106,382,-3,0));
    tbl.push_back(mk(1,0,0, 104,380,-2,0));
    tbl.push_back(mk(1,1,0, 104,379,-1,0));
    tbl.push_back(mk(0,0,0, 104,379,0,0));
    tbl.push_back(mk(0,0,0, 104,380,1,0));
    tbl.push_back(mk(0,0,0, 104,382,2,0));
    tbl.push_back(mk(0,0,0, 104,385,3,0));
    tbl.push_back(mk(0,0,0, 104,389,4,0));
    tbl.push_back(mk(0,0,0, 104,394,5,0));
    tbl.push_back(mk(0,0,0, 104,400,6,0));
    tbl.push_back(mk(0,0,0, 104,407,7,0));
    tbl.push_back(mk(0,0,0, 104,415,0,1));

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    modelReset();
    checkValue("reset.x", player_X_Pos, 100);
    checkValue("reset.y", player_Y_Pos, 400);
    checkValue("reset.vy", player_Y_Vel, 0);
    checkValue("reset.grounded", int'(grounded), 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].l, tbl[i].r, tbl[i].j, 1'b0, 0, 639, tbl[i].yMin, tbl[i].yMax);
      checkValue($sformatf("tbl%0d.x", i), player_X_Pos, tbl[i].expX);
      checkValue($sformatf("tbl%0d.y", i), player_Y_Pos, tbl[i].expY);
      checkValue($sformatf("tbl%0d.vy", i), player_Y_Vel, tbl[i].expVy);
      checkValue($sformatf("tbl%0d.grounded", i), int'(grounded), int'(tbl[i].expG));
    end

    // update lands exactly on the fourth Clk edge after the frame_clk edge
    @(negedge Clk);
    key_left = 1'b0; key_right = 1'b1; key_jump = 1'b0;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 checkValue("latency.before", player_X_Pos, 104);
    @(posedge Clk);
    #1 checkValue("latency.after", player_X_Pos, 106);
    repeat (3) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    modelStep(0, 1, 0, 0, 639, 0, 415);
    @(negedge Clk);
    checkOutput("latency");

    // head bump against a low ceiling, then fall back to the floor
    applyStimulus(0,0,1,0, 0,639,410,415);
    checkValue("bump.y", player_Y_Pos, 410);
    checkValue("bump.vy", player_Y_Vel, 0);
    checkValue("bump.grounded", int'(grounded), 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0,0,0,0, 0,639,0,415);
      checkOutput($sformatf("bumpfall%0d", k));
    end
    checkValue("bump.landed", int'(grounded), 1);

    // right-edge clamp and both-keys cancel
    applyStimulus(0,0,0,0, 637,639,0,415);
    checkValue("xedge.snap", player_X_Pos, 637);
    applyStimulus(0,1,0,0, 0,639,0,415);
    checkValue("xedge.first", player_X_Pos, 639);
    applyStimulus(0,1,0,0, 0,639,0,415);
    checkValue("xedge.hold", player_X_Pos, 639);
    applyStimulus(1,1,0,0, 0,639,0,415);
    checkValue("xedge.both", player_X_Pos, 639);

    // walking off a ledge
    applyStimulus(0,0,0,0, 0,639,0,479);
    checkValue("ledge.y", player_Y_Pos, 416);
    checkValue("ledge.vy", player_Y_Vel, 1);
    checkValue("ledge.grounded", int'(grounded), 0);
    applyStimulus(0,0,0,0, 0,639,0,415);
    checkOutput("ledge.land");

    // freeze drops ticks entirely
    applyStimulus(0,0,1,0, 0,639,0,415);
    checkValue("jump.y", player_Y_Pos, 407);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1,0,1,1, 0,639,0,415);
      checkValue($sformatf("freeze%0d.x", k), player_X_Pos, 639);
      checkValue($sformatf("freeze%0d.y", k), player_Y_Pos, 407);
      checkValue($sformatf("freeze%0d.vy", k), player_Y_Vel, -8);
    end
    applyStimulus(0,0,0,0, 0,639,0,415);
    checkOutput("unfreeze");

    // asynchronous reset mid-jump, released while frame_clk is high
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    checkValue("midreset.x", player_X_Pos, 100);
    checkValue("midreset.y", player_Y_Pos, 400);
    checkValue("midreset.vy", player_Y_Vel, 0);
    checkValue("midreset.grounded", int'(grounded), 0);
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    modelReset();
    checkOutput("highAtRelease");
    frame_clk = 1'b0;
    repeat (6) @(posedge Clk);

    // randomized frames against the model
    for (int n = 0; n < 300; n++) begin
      bit l, r, j, f;
      int xmin, xmax, ymin, ymax;
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      xmin = $urandom_range(0, 60);
      xmax = $urandom_range(580, 639);
      ymin = $urandom_range(0, 120);
      ymax = $urandom_range(380, 479);
      applyStimulus(l, r, j, f, xmin, xmax, ymin, ymax);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
